// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a one-outstanding req/rvalid handshake to
// instruction memory and presents {instr, pc, pc+4} to IF/ID through a one-entry skid buffer.
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc_plus4_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        slot_valid_q, slot_valid_d;
  logic [31:0] slot_instr_q, slot_instr_d;
  logic [31:0] slot_pc_q, slot_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic consume;
  logic slot_open;

  // Redirect suppresses the consume so a squashed instruction is never counted.
  assign consume   = slot_valid_q & ~stall_i & ~redirect_i;
  assign slot_open = ~slot_valid_q | ~stall_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      addr_q        <= RESET_PC;
      slot_valid_q  <= 1'b0;
      slot_instr_q  <= NOP_INSTR;
      slot_pc_q     <= 32'd0;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= NOP_INSTR;
      skid_pc_q     <= 32'd0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      slot_valid_q  <= slot_valid_d;
      slot_instr_q  <= slot_instr_d;
      slot_pc_q     <= slot_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    slot_valid_d  = slot_valid_q;
    slot_instr_d  = slot_instr_q;
    slot_pc_d     = slot_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    fetch_count_d = fetch_count_q;

    if (consume) begin
      fetch_count_d = fetch_count_q + 32'd1;
      slot_valid_d  = 1'b0;
    end

    if (redirect_i) begin
      pc_d         = redirect_pc_i & ~32'd3;
      slot_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      // An unanswered request must still be drained so its stale response is dropped.
      unique case (state_q)
        StReq, StDrain: state_d = imem_rvalid_i ? StReq : StDrain;
        default:        state_d = StReq;
      endcase
    end else begin
      unique case (state_q)
        StIdle: state_d = StReq;
        StReq: begin
          if (imem_rvalid_i) begin
            pc_d = pc_q + 32'd4;
            if (slot_open) begin
              slot_valid_d = 1'b1;
              slot_instr_d = imem_rdata_i;
              slot_pc_d    = pc_q;
            end else begin
              skid_valid_d = 1'b1;
              skid_instr_d = imem_rdata_i;
              skid_pc_d    = pc_q;
              state_d      = StHold;
            end
          end
        end
        StHold: begin
          if (slot_open) begin
            slot_valid_d = skid_valid_q;
            slot_instr_d = skid_instr_q;
            slot_pc_d    = skid_pc_q;
            skid_valid_d = 1'b0;
            state_d      = StReq;
          end
        end
        StDrain: begin
          if (imem_rvalid_i) state_d = StReq;
        end
        default: state_d = StIdle;
      endcase
    end

    // The address only moves when a fresh request is about to be presented.
    addr_d = (state_d == StReq) ? pc_d : addr_q;
  end

  always_comb begin
    imem_req_o    = (state_q == StReq) || (state_q == StDrain);
    imem_addr_o   = addr_q;
    if_valid_o    = slot_valid_q;
    if_instr_o    = slot_valid_q ? slot_instr_q : NOP_INSTR;
    if_pc_o       = slot_pc_q;
    if_pc_plus4_o = slot_pc_q + 32'd4;
    fetch_count_o = fetch_count_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a variable-latency memory returning ~addr and a stream-level
// model of the expected instruction sequence, request addresses and consume count.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0040_0000;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc_plus4_o;
  logic [31:0] fetch_count_o;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_instr_o    (if_instr_o),
    .if_pc_o       (if_pc_o),
    .if_pc_plus4_o (if_pc_plus4_o),
    .fetch_count_o (fetch_count_o)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model state: next expected presented PC, consume count, next fresh request address.
  logic [31:0] exp_pc;
  logic [31:0] exp_count;
  logic [31:0] next_req_addr;
  logic [31:0] mem_addr;
  bit          mem_busy;
  int          mem_left;
  bit          redirect_prev;
  int          stall_left;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_pc        = ResetPc;
    exp_count     = 32'd0;
    next_req_addr = ResetPc;
    mem_busy      = 1'b0;
    mem_left      = 0;
    redirect_prev = 1'b0;
    stall_left    = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_req", {31'd0, imem_req_o}, 32'd0);
    check("rst_addr", imem_addr_o, ResetPc);
    check("rst_valid", {31'd0, if_valid_o}, 32'd0);
    check("rst_instr", if_instr_o, Nop);
    check("rst_pc", if_pc_o, 32'd0);
    check("rst_pc4", if_pc_plus4_o, 32'd4);
    check("rst_count", fetch_count_o, 32'd0);
  endtask

  // One cycle: observe at negedge, run the memory model, choose stall/redirect, update model.
  // stall_mode: 0 random, 1 always stalled, 2 never stalled. redir_pct=100 forces a redirect.
  task automatic step(input int redir_pct, input int stall_mode);
    logic        stall;
    logic        redir;
    logic [31:0] target;
    @(negedge clk);
    check("count", fetch_count_o, exp_count);
    if (redirect_prev) check("valid_after_redirect", {31'd0, if_valid_o}, 32'd0);
    if (if_valid_o) begin
      check("head_pc", if_pc_o, exp_pc);
      check("head_instr", if_instr_o, ~exp_pc);
    end else begin
      check("idle_instr", if_instr_o, Nop);
    end

    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'hDEAD_BEEF;
    if (mem_busy) begin
      check("req_held", {31'd0, imem_req_o}, 32'd1);
      check("addr_held", imem_addr_o, mem_addr);
      mem_left--;
      if (mem_left == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = ~mem_addr;
        mem_busy      = 1'b0;
      end
    end else if (imem_req_o) begin
      check("req_addr", imem_addr_o, next_req_addr);
      mem_addr      = next_req_addr;
      next_req_addr = next_req_addr + 32'd4;
      mem_busy      = 1'b1;
      mem_left      = $urandom_range(1, 4);
    end

    if (stall_mode == 1) stall = 1'b1;
    else if (stall_mode == 2) stall = 1'b0;
    else if (stall_left > 0) begin
      stall = 1'b1;
      stall_left--;
    end else if ($urandom_range(0, 7) == 0) begin
      stall      = 1'b1;
      stall_left = $urandom_range(0, 6);
    end else stall = 1'b0;

    redir  = ($urandom_range(0, 99) < redir_pct);
    target = ResetPc + $urandom_range(0, 1023);

    if (if_valid_o && !stall && !redir) begin
      check("consume_pc4", if_pc_plus4_o, exp_pc + 32'd4);
      exp_pc    = exp_pc + 32'd4;
      exp_count = exp_count + 32'd1;
    end
    if (redir) begin
      exp_pc        = target & ~32'd3;
      next_req_addr = target & ~32'd3;
    end
    redirect_prev = redir;

    stall_i       = stall;
    redirect_i    = redir;
    redirect_pc_i = redir ? target : 32'h0;
  endtask

  initial begin
    bit found;
    reset         = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    model_reset();
    #12;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b1;

    // Straight-line fetch, no stalls.
    for (int i = 0; i < 30; i++) step(0, 2);

    // Hold stall long enough to fill slot and skid: fetch must park with req low.
    for (int i = 0; i < 14; i++) step(0, 1);
    check("hold_req_low", {31'd0, imem_req_o}, 32'd0);
    check("hold_slot_valid", {31'd0, if_valid_o}, 32'd1);
    for (int i = 0; i < 20; i++) step(0, 2);

    // Fill the skid again, then redirect while stalled: both entries dropped.
    for (int i = 0; i < 14; i++) step(0, 1);
    step(100, 1);
    for (int i = 0; i < 20; i++) step(0, 2);

    // Redirect to an unaligned target while a request is outstanding.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(0, 2);
      found = mem_busy && (mem_left > 1);
    end
    check("found_outstanding", {31'd0, found}, 32'd1);
    step(100, 2);
    for (int i = 0; i < 20; i++) step(0, 0);

    // Main randomized run.
    for (int i = 0; i < 2000; i++) step(5, 0);

    // Asynchronous reset in the middle of an outstanding request.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(0, 2);
      found = mem_busy;
    end
    check("found_busy", {31'd0, found}, 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_outputs();
    imem_rvalid_i = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;
    for (int i = 0; i < 30; i++) step(0, 0);

    // Counter wrap: hold the count at 2^32-2 across one stalled edge, then let it run.
    for (int i = 0; i < 3; i++) step(0, 1);
    force dut.fetch_count_q = 32'hFFFF_FFFE;
    exp_count = 32'hFFFF_FFFE;
    step(0, 1);
    release dut.fetch_count_q;
    for (int i = 0; i < 60; i++) step(0, 2);
    for (int i = 0; i < 200; i++) step(3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the pipelined RISC-V core. Owns the program counter, issues one-at-a-time requests to instruction memory over a req/rvalid handshake, and presents {instruction, PC, PC+4} with a valid flag to the IF/ID pipeline register. Handles hazard stalls with a one-entry skid buffer and branch/jump redirects, including discarding a stale in-flight response.

## Interface
- RESET_PC, 32'h0040_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, value of if_instr_o whenever no valid instruction is presented (addi x0,x0,0)
- clk  input  1  clock, rising edge
- reset  input  1  reset, asynchronous, active-low
- stall_i  input  1  hazard hold; same signal drives the IF/ID enable port (IF/ID loads when 0)
- redirect_i  input  1  taken branch/jump from the execute stage
- redirect_pc_i  input  32  redirect target
- imem_req_o  output  1  instruction-memory request
- imem_addr_o  output  32  request address, word aligned
- imem_rvalid_i  input  1  response valid, one pulse per request
- imem_rdata_i  input  32  response instruction
- if_valid_o  output  1  presented instruction is valid
- if_instr_o  output  32  instruction to IF/ID
- if_pc_o  output  32  PC of presented instruction
- if_pc_plus4_o  output  32  if_pc_o + 4
- fetch_count_o  output  32  instructions consumed by IF/ID, wraps modulo 2^32

## Operation
- Registers: pc, state, output slot {if_valid_o, instr, pc}, skid {valid, instr, pc}, fetch_count.
- Reset (reset=0, immediate): pc=RESET_PC, state=IDLE, imem_req_o=0, imem_addr_o=RESET_PC, if_valid_o=0, if_instr_o=NOP_INSTR, if_pc_o=0, if_pc_plus4_o=4, skid empty, fetch_count_o=0.
- Consume: a cycle with if_valid_o=1 and stall_i=0; increments fetch_count_o, slot frees unless refilled at the same edge.
- States:
  - IDLE: req low; next cycle -> REQ unconditionally.
  - REQ: imem_req_o=1, imem_addr_o=pc. On rvalid: if slot free or being consumed, load slot (valid=1, instr=rdata, pc), else load skid and go HOLD; pc<=pc+4 in both cases.
  - HOLD: req low. When slot frees (consumed, or skid moves into an empty slot), skid moves to slot, skid clears, -> REQ.
  - DRAIN: req held high with old address until rvalid; response discarded; -> REQ with pc.
- Handshake: once imem_req_o rises, it and imem_addr_o stay stable until the rvalid cycle; a request is complete on rvalid; if req stays high the following cycle, that cycle starts a new request at the new address.
- Redirect (highest priority, any state): pc<=redirect_pc_i with bits[1:0] forced to 0; slot and skid invalidated (if_instr_o=NOP_INSTR); no consume counted that cycle.
  - REQ without rvalid -> DRAIN. REQ with rvalid -> response discarded, stay REQ. DRAIN without rvalid -> stay DRAIN, pc updated. DRAIN with rvalid -> REQ. HOLD/IDLE -> REQ.
- Stall never blocks redirect; stall alone never drops an outstanding request.

## Timing
- Memory latency >=1: rvalid earliest in the cycle after req rises.
- With 1-cycle memory: req at cycle t, rvalid t+1, if_valid_o=1 at t+2. Sustained throughput one instruction per 2 cycles.
- Outputs are all registered; if_pc_plus4_o is updated with if_pc_o at the same edge.
- Redirect at cycle t: if_valid_o=0 at t+1; with no outstanding request, req at redirect target in t+1, first valid instruction at t+3 (1-cycle memory). Outstanding request adds the remaining drain latency.
- Reset asserted mid-request: all state clears immediately; memory must tolerate an abandoned request.

## Test plan
- Reset release, 1-cycle memory returning addr^32'hFFFF_FFFF, no stall -> addresses 0x0040_0000, 0x0040_0004, ... ; if_pc_o/if_pc_plus4_o match; fetch_count_o=4 after four consumes.
- Stall held 5 cycles while a response arrives with full slot -> skid filled, HOLD with req low, slot unchanged; on release instructions delivered in order, none lost or duplicated.
- Redirect to 0x0040_0103 while a 4-cycle-latency request is outstanding -> DRAIN, stale data never valid, next request addr 0x0040_0100.
- Redirect and rvalid in same cycle, plus redirect during stall with skid full -> both discarded, if_valid_o=0 next cycle, fetch resumes at target.
- Reset pulsed mid-WAIT -> all outputs to reset values immediately, refetch from RESET_PC.
- fetch_count_o preloaded-equivalent run past 2^32-1 (forced) -> wraps to 0.
